// File: rtl/bcd_multidecade_counter.sv
// bcd_multidecade_counter
// Multi-decade BCD up/down counter with parallel load, digit validation on
// load, and selectable wrap-around or saturation at the count limits.
// tc is combinational from Q and up. wrap and load_err are registered
// single-cycle pulses.

module bcd_multidecade_counter #(
  parameter int DIGITS = 4,   // number of BCD decades (1..8)
  parameter bit WRAP   = 1'b1 // 1: roll over at the limits, 0: saturate
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [DIGITS-1:0]   at_lim;    // digit sits at its limit for the current direction
  logic [DIGITS-1:0]   dig_en;    // digit steps on this edge
  logic [4*DIGITS-1:0] q_step;    // count after one step, rolled over at the limits
  logic [4*DIGITS-1:0] load_fix;  // load value with out-of-range digits clamped to 9
  logic                load_bad;  // some load digit was above 9

  // Carry/borrow chain: each digit steps when every lower digit is at its limit.
  // Built as a running AND, so tc is the chain's carry-out (all digits at limit).
  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    logic run;
    at_lim = '0;
    dig_en = '0;
    q_step = Q;
    run    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_lim[i] = up ? (Q[4*i +: 4] == 4'd9) : (Q[4*i +: 4] == 4'd0);
      dig_en[i] = run;
      run       = run & at_lim[i];
      if (dig_en[i]) begin
        if (up) q_step[4*i +: 4] = at_lim[i] ? 4'd0 : Q[4*i +: 4] + 4'd1;
        else    q_step[4*i +: 4] = at_lim[i] ? 4'd9 : Q[4*i +: 4] - 4'd1;
      end
    end
    tc = run;
  end

  // Load validation: clamp any non-BCD digit to 9 and flag it.
  always_comb begin
    load_fix = load_val;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_fix[4*i +: 4] = 4'd9;
        load_bad           = 1'b1;
      end
    end
  end

  // Count register and status pulses; priority reset > load > en.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q        <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      Q        <= load_fix;
      wrap     <= 1'b0;
      load_err <= load_bad;
    end else if (en) begin
      // At the limit a saturating counter holds; otherwise take the step.
      if (WRAP || !tc) Q <= q_step;
      wrap     <= tc;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_multidecade_counter.sv
// tb_bcd_multidecade_counter
// Directed bench for a 4-digit counter, with one wrapping and one saturating
// instance sharing the same stimulus, followed by a random run checked
// against a decimal integer model.

module tb_bcd_multidecade_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] q_w, q_s;
  logic        tc_w, tc_s, wrap_w, wrap_s, lerr_w, lerr_s;

  int vectors    = 0;
  int miscompares = 0;

  // model state for the random run
  int m_w, m_s;
  logic e_wrap_w, e_wrap_s, e_lerr;

  always #5 clk = ~clk;

  bcd_multidecade_counter #(.DIGITS(4), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .Q(q_w), .tc(tc_w), .wrap(wrap_w), .load_err(lerr_w)
  );

  bcd_multidecade_counter #(.DIGITS(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .Q(q_s), .tc(tc_s), .wrap(wrap_s), .load_err(lerr_s)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_int(input logic [15:0] b);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic has_bad(input logic [15:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  initial begin
    // ---- reset while counting ----
    reset = 1'b0; en = 1'b1; up = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_q",      q_w,    16'h0000);
    chk("rst_q_s",    q_s,    16'h0000);
    chk("rst_wrap",   wrap_w, 16'h0);
    chk("rst_lerr",   lerr_w, 16'h0);
    tick();
    chk("rst_hold_q", q_w,    16'h0000);

    // ---- load 0099 then count up across two carries ----
    reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'h0099;
    tick();
    chk("ld99_q",    q_w,    16'h0099);
    chk("ld99_lerr", lerr_w, 16'h0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("up_0100",   q_w,    16'h0100);
    chk("up_wrap0",  wrap_w, 16'h0);
    tick();
    chk("up_0101",   q_w,    16'h0101);
    chk("up_wrap0b", wrap_w, 16'h0);

    // ---- upper limit: wrap vs saturate ----
    en = 1'b0; load = 1'b1; load_val = 16'h9999;
    tick();
    load = 1'b0;
    chk("tc_9999_up", tc_w, 16'h1);
    en = 1'b1;
    tick();
    chk("wrapup_q",   q_w,    16'h0000);
    chk("wrapup_w",   wrap_w, 16'h1);
    chk("satup_q",    q_s,    16'h9999);
    chk("satup_w",    wrap_s, 16'h1);
    en = 1'b0;
    tick();
    chk("wrap_pulse_drop", wrap_w, 16'h0);

    // ---- lower limit: down from 0000 on the wrapping instance ----
    up = 1'b0;
    #1;
    chk("tc_0000_dn", tc_w, 16'h1);
    chk("tc_9999_dn", tc_s, 16'h0);
    en = 1'b1;
    tick();
    chk("wrapdn_q",   q_w,    16'h9999);
    chk("wrapdn_w",   wrap_w, 16'h1);
    chk("satdn_9998", q_s,    16'h9998);
    chk("satdn_w0",   wrap_s, 16'h0);

    // ---- saturating hold at 9999 ----
    en = 1'b0; up = 1'b1; load = 1'b1; load_val = 16'h9998;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("sat1_q",  q_s,    16'h9999);
    chk("sat1_w",  wrap_s, 16'h0);
    chk("sat1_tc", tc_s,   16'h1);
    chk("wr1_q",   q_w,    16'h9999);
    tick();
    chk("sat2_q",  q_s,    16'h9999);
    chk("sat2_w",  wrap_s, 16'h1);
    chk("wr2_q",   q_w,    16'h0000);
    tick();
    chk("sat3_q",  q_s,    16'h9999);
    chk("sat3_w",  wrap_s, 16'h1);
    chk("wr3_q",   q_w,    16'h0001);
    chk("wr3_w",   wrap_w, 16'h0);

    // ---- invalid digits clamp; load beats en ----
    load = 1'b1; load_val = 16'h1A3F; en = 1'b1;
    tick();
    chk("clamp_q",    q_w,    16'h1939);
    chk("clamp_lerr", lerr_w, 16'h1);
    chk("clamp_wrap", wrap_w, 16'h0);
    load = 1'b0; en = 1'b0;
    tick();
    chk("hold_q",     q_w,    16'h1939);
    chk("lerr_drop",  lerr_w, 16'h0);

    // ---- borrow ripple through three zeros ----
    load = 1'b1; load_val = 16'h1000;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk("borrow_0999", q_w, 16'h0999);

    // ---- tc follows up without a clock edge ----
    en = 1'b0; load = 1'b1; load_val = 16'h0000;
    tick();
    load = 1'b0; up = 1'b0;
    #1;
    chk("tc_dn_zero", tc_w, 16'h1);
    up = 1'b1;
    #1;
    chk("tc_up_zero", tc_w, 16'h0);

    // ---- reset mid-count, then first steps after release ----
    load = 1'b1; load_val = 16'h4567;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_q", q_w, 16'h0000);
    reset = 1'b0;
    tick();
    chk("post_rst_up", q_w, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0; up = 1'b0;
    tick();
    chk("post_rst_dn_w", q_w,    16'h9999);
    chk("post_rst_dn_s", q_s,    16'h0000);
    chk("post_rst_dn_sw", wrap_s, 16'h1);

    // ---- random run against a decimal model ----
    en = 1'b0; load = 1'b1; load_val = 16'h0000;
    tick();
    m_w = 0; m_s = 0;
    for (int n = 0; n < 4000; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 3) != 0) ? (n[9] == 1'b0) : 1'($urandom);
      load = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 16'h9997;
        1:       load_val = 16'h0002;
        default: load_val = 16'($urandom);
      endcase
      #1;
      chk("rnd_tc_w", tc_w, 16'(up ? (m_w == 9999) : (m_w == 0)));
      chk("rnd_tc_s", tc_s, 16'(up ? (m_s == 9999) : (m_s == 0)));
      e_wrap_w = 1'b0; e_wrap_s = 1'b0; e_lerr = 1'b0;
      if (load) begin
        m_w = load_int(load_val);
        m_s = m_w;
        e_lerr = has_bad(load_val);
      end else if (en) begin
        if (up) begin
          e_wrap_w = (m_w == 9999);
          m_w = e_wrap_w ? 0 : m_w + 1;
          e_wrap_s = (m_s == 9999);
          if (!e_wrap_s) m_s = m_s + 1;
        end else begin
          e_wrap_w = (m_w == 0);
          m_w = e_wrap_w ? 9999 : m_w - 1;
          e_wrap_s = (m_s == 0);
          if (!e_wrap_s) m_s = m_s - 1;
        end
      end
      tick();
      chk("rnd_q_w",    q_w,    to_bcd(m_w));
      chk("rnd_q_s",    q_s,    to_bcd(m_s));
      chk("rnd_wrap_w", wrap_w, 16'(e_wrap_w));
      chk("rnd_wrap_s", wrap_s, 16'(e_wrap_s));
      chk("rnd_lerr",   lerr_w, 16'(e_lerr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
